// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one Y86-64 ALU between execute and address calc.
// Owns the one-entry response buffer and the architectural condition codes.
module alu_arbiter #(
  parameter int WIDTH = 64,
  parameter int FUN_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [FUN_W-1:0] req0_fun,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_set_cc,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [FUN_W-1:0] req1_fun,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_set_cc,
  output logic [FUN_W-1:0] alu_fun,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_valE,
  input  logic             alu_zf,
  input  logic             alu_sf,
  input  logic             alu_of,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_valE,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t state;
  logic   last_grant;
  logic   grant_any;
  logic   grant_sel;
  logic   can_accept;
  logic   accept;
  logic   sel_cc;

  // With no request, grant_sel parks on last_grant so the ALU drive is stable.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_sel = last_grant;
    unique case ({req1_valid, req0_valid})
      2'b01:   grant_sel = 1'b0;
      2'b10:   grant_sel = 1'b1;
      2'b11:   grant_sel = ~last_grant;
      default: grant_sel = last_grant;
    endcase
  end

  assign can_accept = rst_n & ((state == IDLE) | resp_ready);
  assign accept     = can_accept & grant_any;
  assign req0_ready = accept & ~grant_sel;
  assign req1_ready = accept & grant_sel;

  assign alu_fun = grant_sel ? req1_fun : req0_fun;
  assign alu_a   = grant_sel ? req1_a : req0_a;
  assign alu_b   = grant_sel ? req1_b : req0_b;
  assign sel_cc  = grant_sel ? req1_set_cc : req0_set_cc;

  assign resp_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      resp_id    <= 1'b0;
      resp_valE  <= '0;
      cc_zf      <= 1'b1;
      cc_sf      <= 1'b0;
      cc_of      <= 1'b0;
    end else if (accept) begin
      state      <= HOLD;
      last_grant <= grant_sel;
      resp_id    <= grant_sel;
      resp_valE  <= alu_valE;
      if (sel_cc) begin
        cc_zf <= alu_zf;
        cc_sf <= alu_sf;
        cc_of <= alu_of;
      end
    end else if (state == HOLD && resp_ready) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural Y86-64 ALU on the side.
// Expected values are hand-computed constants.
module tb_alu_arbiter;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_set_cc;
  logic [1:0]   req0_fun;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_set_cc;
  logic [1:0]   req1_fun;
  logic [W-1:0] req1_a, req1_b;
  logic [1:0]   alu_fun;
  logic [W-1:0] alu_a, alu_b, alu_valE;
  logic         alu_zf, alu_sf, alu_of;
  logic         resp_valid, resp_ready, resp_id;
  logic [W-1:0] resp_valE;
  logic         cc_zf, cc_sf, cc_of;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .FUN_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_fun(req0_fun), .req0_a(req0_a), .req0_b(req0_b),
    .req0_set_cc(req0_set_cc),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_fun(req1_fun), .req1_a(req1_a), .req1_b(req1_b),
    .req1_set_cc(req1_set_cc),
    .alu_fun(alu_fun), .alu_a(alu_a), .alu_b(alu_b),
    .alu_valE(alu_valE), .alu_zf(alu_zf), .alu_sf(alu_sf),
    .alu_of(alu_of),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_valE(resp_valE),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  // Y86-64 ALU: valE = B op A
  always_comb begin
    alu_valE = '0;
    alu_of   = 1'b0;
    case (alu_fun)
      2'd0: begin
        alu_valE = alu_b + alu_a;
        alu_of = (alu_a[W-1] == alu_b[W-1]) &&
                 (alu_valE[W-1] != alu_a[W-1]);
      end
      2'd1: begin
        alu_valE = alu_b - alu_a;
        alu_of = (alu_a[W-1] != alu_b[W-1]) &&
                 (alu_valE[W-1] != alu_b[W-1]);
      end
      2'd2: alu_valE = alu_a & alu_b;
      default: alu_valE = alu_a ^ alu_b;
    endcase
    alu_zf = (alu_valE == '0);
    alu_sf = alu_valE[W-1];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_set_cc = 0; req1_set_cc = 0;
    req0_fun = 0; req1_fun = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    resp_ready = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready});
    end
    step();
    n_checks++;
    if ({resp_valid, resp_id, resp_valE} !== {1'b0, 1'b0, 64'd0}) begin
      n_errors++;
      $display("FAIL reset_resp got v=%b id=%b valE=%h want 0/0/0",
               resp_valid, resp_id, resp_valE);
    end
    n_checks++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
      n_errors++;
      $display("FAIL reset_cc got=%b want=100", {cc_zf, cc_sf, cc_of});
    end
    rst_n = 1;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (^{alu_fun, alu_a, alu_b} === 1'bx) begin
      n_errors++;
      $display("FAIL idle_alu_drive got fun=%b a=%h want no X", alu_fun, alu_a);
    end
    step();
  endtask

  task automatic test_add();
    req0_valid = 1; req0_fun = 2'd0;
    req0_a = 64'd5; req0_b = 64'd7; req0_set_cc = 1;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_errors++;
      $display("FAIL add_ready got=%b want=10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 0; req0_set_cc = 0;
    n_checks++;
    if ({resp_valid, resp_id, resp_valE} !== {1'b1, 1'b0, 64'd12}) begin
      n_errors++;
      $display("FAIL add_resp got v=%b id=%b valE=%0d want 1/0/12",
               resp_valid, resp_id, resp_valE);
    end
    n_checks++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin
      n_errors++;
      $display("FAIL add_cc got=%b want=000", {cc_zf, cc_sf, cc_of});
    end
    resp_ready = 1;
    step();
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL add_drain got v=%b want=0", resp_valid);
    end
    resp_ready = 1;
    step();
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_resp_ready got v=%b want=0", resp_valid);
    end
    resp_ready = 0;
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_val;
    apply_reset();
    idle_inputs();
    req0_valid = 1; req0_fun = 2'd1;
    req0_a = 64'd3; req0_b = 64'd3; req0_set_cc = 1;
    req1_valid = 1; req1_fun = 2'd0;
    req1_a = 64'd8; req1_b = 64'd16; req1_set_cc = 0;
    resp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_errors++;
        $display("FAIL rr_ready[%0d] got=%b want=%b", i,
                 {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      step();
      exp_val = (i % 2 == 0) ? 64'd0 : 64'd24;
      n_checks++;
      if ({resp_valid, resp_id, resp_valE, cc_zf} !==
          {1'b1, i[0], exp_val, 1'b1}) begin
        n_errors++;
        $display("FAIL rr_resp[%0d] got v=%b id=%b valE=%0d zf=%b want 1/%0d/%0d/1",
                 i, resp_valid, resp_id, resp_valE, cc_zf, i % 2, exp_val);
      end
    end
    idle_inputs();
    resp_ready = 1;
    step();
    resp_ready = 0;
  endtask

  task automatic test_overflow();
    req1_valid = 1; req1_fun = 2'd0;
    req1_a = 64'h7FFF_FFFF_FFFF_FFFF; req1_b = 64'd1; req1_set_cc = 1;
    step();
    req1_valid = 0; req1_set_cc = 0;
    n_checks++;
    if ({resp_id, resp_valE} !== {1'b1, 64'h8000_0000_0000_0000}) begin
      n_errors++;
      $display("FAIL ovf_resp got id=%b valE=%h want 1/8000000000000000",
               resp_id, resp_valE);
    end
    n_checks++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b011) begin
      n_errors++;
      $display("FAIL ovf_cc got=%b want=011", {cc_zf, cc_sf, cc_of});
    end
    resp_ready = 1;
    step();
    resp_ready = 0;
  endtask

  task automatic test_stall();
    req0_valid = 1; req0_fun = 2'd0;
    req0_a = 64'd1; req0_b = 64'd2; req0_set_cc = 0;
    step();
    req0_fun = 2'd1; req0_a = 64'd1; req0_b = 64'd10; req0_set_cc = 1;
    resp_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (req0_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_ready[%0d] got=%b want=0", i, req0_ready);
      end
      step();
      n_checks++;
      if ({resp_valid, resp_valE, cc_zf, cc_sf, cc_of} !==
          {1'b1, 64'd3, 3'b011}) begin
        n_errors++;
        $display("FAIL stall_hold[%0d] got v=%b valE=%0d cc=%b want 1/3/011",
                 i, resp_valid, resp_valE, {cc_zf, cc_sf, cc_of});
      end
    end
    resp_ready = 1;
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_release got=%b want=1", req0_ready);
    end
    step();
    req0_valid = 0; req0_set_cc = 0;
    n_checks++;
    if ({resp_valid, resp_id, resp_valE, cc_zf, cc_sf, cc_of} !==
        {1'b1, 1'b0, 64'd9, 3'b000}) begin
      n_errors++;
      $display("FAIL stall_next got v=%b id=%b valE=%0d cc=%b want 1/0/9/000",
               resp_valid, resp_id, resp_valE, {cc_zf, cc_sf, cc_of});
    end
    step();
    resp_ready = 0;
  endtask

  task automatic test_reset_mid();
    req0_valid = 1; req0_fun = 2'd1;
    req0_a = 64'd5; req0_b = 64'd2; req0_set_cc = 1;
    step();
    n_checks++;
    if ({resp_valid, cc_zf, cc_sf, cc_of} !== 4'b1010) begin
      n_errors++;
      $display("FAIL mid_accept got v=%b cc=%b want 1/010",
               resp_valid, {cc_zf, cc_sf, cc_of});
    end
    req1_valid = 1; req1_fun = 2'd0;
    req1_a = 64'd1; req1_b = 64'd1; req1_set_cc = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    n_checks++;
    if ({resp_valid, cc_zf, cc_sf, cc_of} !== 4'b0100) begin
      n_errors++;
      $display("FAIL mid_reset got v=%b cc=%b want 0/100",
               resp_valid, {cc_zf, cc_sf, cc_of});
    end
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_errors++;
      $display("FAIL mid_first_grant got=%b want=10", {req0_ready, req1_ready});
    end
    step();
    idle_inputs();
    resp_ready = 1;
    step();
    resp_ready = 0;
  endtask

  task automatic test_no_cc();
    req0_valid = 1; req0_fun = 2'd0;
    req0_a = 64'd5; req0_b = 64'd7; req0_set_cc = 1;
    step();
    req0_fun = 2'd3; req0_a = 64'hFF; req0_b = 64'hFF; req0_set_cc = 0;
    resp_ready = 1;
    step();
    req0_valid = 0;
    n_checks++;
    if ({resp_valid, resp_valE, cc_zf, cc_sf, cc_of} !==
        {1'b1, 64'd0, 3'b000}) begin
      n_errors++;
      $display("FAIL xor_no_cc got v=%b valE=%h cc=%b want 1/0/000",
               resp_valid, resp_valE, {cc_zf, cc_sf, cc_of});
    end
    step();
    resp_ready = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_add();
    test_round_robin();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_no_cc();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
